adder_share_arbiter: RTL and testbench

Round-robin arbiter that shares one `carry_select_adder` instance among `NUM_REQ` requesters using a valid/ready handshake. It holds each result, together with its carry-out and the requester ID, in a single-entry output register until the consumer accepts it. It sits between several datapath clients and one adder instance, so the adder area is paid once. Throughput is one addition per cycle under no backpressure.

---
 rtl/adder_share_pkg.sv | 20 ++
 rtl/carry_select_adder.sv | 33 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/adder_share_arbiter.sv | 133 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// Shared types for the adder-sharing arbiter.
package adder_share_pkg;

    localparam int unsigned CSA_DATA_WIDTH  = 32;
    localparam int unsigned CSA_BLOCK_WIDTH = 4;

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fsm_state_t;

    // One adder request at the package default width
    typedef struct packed {
        logic [CSA_DATA_WIDTH-1:0] a;
        logic [CSA_DATA_WIDTH-1:0] b;
        logic                      carry;
    } csa_req_t;

endpackage

// File: rtl/carry_select_adder.sv
// Carry-select adder: each block precomputes sums for carry-in 0 and 1, the ripple carry selects.
module carry_select_adder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BLOCK_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  carry_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  carry_o
);

    localparam int unsigned NUM_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;

    logic [NUM_BLOCKS:0] c;

    assign c[0] = carry_i;

    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_blk
        logic [BLOCK_WIDTH:0] s0;
        logic [BLOCK_WIDTH:0] s1;

        assign s0 = {1'b0, a_i[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                  + {1'b0, b_i[g*BLOCK_WIDTH +: BLOCK_WIDTH]};
        assign s1 = s0 + {{BLOCK_WIDTH{1'b0}}, 1'b1};

        assign sum_o[g*BLOCK_WIDTH +: BLOCK_WIDTH] = c[g] ? s1[BLOCK_WIDTH-1:0] : s0[BLOCK_WIDTH-1:0];
        assign c[g+1]                              = c[g] ? s1[BLOCK_WIDTH]     : s0[BLOCK_WIDTH];
    end

    assign carry_o = c[NUM_BLOCKS];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ  = 4,
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    input  logic                en_i,
    output logic [NUM_REQ-1:0]  grant_o
);

    logic        found;
    int unsigned idx;

    // Scan requests starting at the pointer; the first hit wins
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
        if (!en_i) begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one carry-select adder among NUM_REQ valid/ready requesters,
// with a single-entry output register holding sum, carry-out and requester id.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = CSA_DATA_WIDTH,
    parameter  int unsigned BLOCK_WIDTH = CSA_BLOCK_WIDTH,
    parameter  int unsigned NUM_REQ     = 4,
    localparam int unsigned ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_A_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_B_i,
    input  logic [NUM_REQ-1:0]            req_carry_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         result_o,
    output logic                          carry_o,
    output logic [ID_WIDTH-1:0]           id_o
);

    fsm_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic                  handshake;
    logic [DATA_WIDTH-1:0] sel_a, sel_b, sum;
    logic                  sel_c, sum_c;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  carry_q;
    logic [ID_WIDTH-1:0]   id_q;

    // Reset is folded in so no request looks accepted while reset is held
    assign accept = rst_n_i & ((state_q == EMPTY) | out_ready_i);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (accept),
        .grant_o (grant)
    );

    assign req_ready_o = grant;
    assign handshake   = |grant;

    // One-hot grant to requester index
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = ID_WIDTH'(i);
            end
        end
    end

    assign sel_a = req_operand_A_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b = req_operand_B_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_c = req_carry_i[gnt_idx];

    carry_select_adder #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_add (
        .a_i     (sel_a),
        .b_i     (sel_b),
        .carry_i (sel_c),
        .sum_o   (sum),
        .carry_o (sum_c)
    );

    // Pointer moves past the granted requester on every handshake
    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
        end
    end

    // State and pointer registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: a handshake always fills; a drain without a handshake empties
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (handshake) state_d = FULL;
            FULL: begin
                if (handshake) begin
                    state_d = FULL;
                end else if (out_ready_i) begin
                    state_d = EMPTY;
                end
            end
        endcase
    end

    // FSM output
    always_comb begin
        out_valid_o = (state_q == FULL);
    end

    // Output data register; holds its last value when not loaded
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            id_q     <= '0;
        end else if (handshake) begin
            result_q <= sum;
            carry_q  <= sum_c;
            id_q     <= gnt_idx;
        end
    end

    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign id_o     = id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed sequences, a vector table,
// and randomized traffic compared against a transaction-level reference model.
module tb_adder_share_arbiter;
    import adder_share_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] opA_flat, opB_flat;
    logic [NR-1:0]    req_carry;
    logic [NR-1:0]    req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    result;
    logic             carry;
    logic [1:0]       id;

    always #5 clk = ~clk;

    adder_share_arbiter #(
        .DATA_WIDTH  (DW),
        .BLOCK_WIDTH (4),
        .NUM_REQ     (NR)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .req_valid_i     (req_valid),
        .req_operand_A_i (opA_flat),
        .req_operand_B_i (opB_flat),
        .req_carry_i     (req_carry),
        .req_ready_o     (req_ready),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .result_o        (result),
        .carry_o         (carry),
        .id_o            (id)
    );

    // Requester-side stimulus state
    logic [31:0] opA [NR];
    logic [31:0] opB [NR];
    bit          cin [NR];
    bit          vld [NR];
    bit          rand_mode = 1'b0;

    // Reference model: occupancy, held result, next-priority requester
    bit          m_full;
    logic [31:0] m_res;
    bit          m_c;
    int          m_id;
    int          m_ptr;
    int          n_hs = 0;

    int n_pass = 0;
    int n_total = 0;
    logic [NR-1:0] seen_ready;

    typedef struct {
        int          k;
        csa_req_t    op;
        logic [31:0] exp_res;
        bit          exp_c;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic int pick();
        for (int i = 0; i < NR; i++) begin
            int idx = (m_ptr + i) % NR;
            if (vld[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [63:0] dut_out();
        return {28'b0, out_valid, carry, id, result};
    endfunction

    function automatic logic [63:0] model_out();
        return {28'b0, m_full, m_c, 2'(m_id), m_res};
    endfunction

    task automatic model_reset();
        m_full = 1'b0; m_res = '0; m_c = 1'b0; m_id = 0; m_ptr = 0;
    endtask

    task automatic new_ops(input int k);
        opA[k] = rnd32();
        opB[k] = rnd32();
        cin[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            req_valid[k]            = vld[k];
            opA_flat[k*DW +: DW]    = opA[k];
            opB_flat[k*DW +: DW]    = opB[k];
            req_carry[k]            = cin[k];
        end
    endtask

    // Granted requesters present new work; in random mode idle ones may start requesting
    task automatic refresh(input logic [NR-1:0] granted);
        for (int k = 0; k < NR; k++) begin
            if (granted[k]) begin
                new_ops(k);
                if (rand_mode) vld[k] = ($urandom_range(0, 3) != 0);
            end else if (rand_mode && !vld[k]) begin
                vld[k] = 1'($urandom_range(0, 1));
                new_ops(k);
            end
        end
    endtask

    // One clock cycle, entered and left at posedge+1
    task automatic step(input bit ordy);
        int            g;
        bit            acc;
        logic [NR-1:0] er;
        logic [32:0]   s;
        drive();
        out_ready = ordy;
        @(negedge clk);
        g   = pick();
        acc = !m_full || ordy;
        er  = '0;
        if (acc && g >= 0) er[g] = 1'b1;
        seen_ready = req_ready;
        chk("ready", 64'(req_ready), 64'(er));
        chk("outputs", dut_out(), model_out());
        @(posedge clk);
        if (er != '0) begin
            s      = {1'b0, opA[g]} + {1'b0, opB[g]} + 33'(cin[g]);
            m_res  = s[31:0];
            m_c    = s[32];
            m_id   = g;
            m_full = 1'b1;
            m_ptr  = (g + 1) % NR;
            n_hs++;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        #1;
        refresh(er);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        tbl[0] = '{2, '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0}, 32'h0000_0000, 1'b1};
        tbl[1] = '{1, '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1}, 32'h8000_0000, 1'b0};
        tbl[2] = '{0, '{32'h0000_0000, 32'h0000_0000, 1'b0}, 32'h0000_0000, 1'b0};
        tbl[3] = '{3, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1}, 32'hFFFF_FFFF, 1'b1};
        tbl[4] = '{0, '{32'h1234_5678, 32'h1111_1111, 1'b0}, 32'h2345_6789, 1'b0};
        tbl[5] = '{3, '{32'h0000_000F, 32'h0000_0001, 1'b0}, 32'h0000_0010, 1'b0};
        tbl[6] = '{1, '{32'h0FFF_FFFF, 32'h0000_0000, 1'b1}, 32'h1000_0000, 1'b0};
        tbl[7] = '{2, '{32'h8000_0000, 32'h8000_0000, 1'b0}, 32'h0000_0000, 1'b1};

        model_reset();
        for (int k = 0; k < NR; k++) begin
            vld[k] = 1'b1;
            new_ops(k);
        end
        drive();
        out_ready = 1'b1;

        // Reset held with every requester valid
        repeat (3) begin
            @(negedge clk);
            chk("reset_ready", 64'(req_ready), 64'h0);
            chk("reset_outputs", dut_out(), 64'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin with all requesters valid and no backpressure
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            chk("rr_grant", 64'(seen_ready), 64'(1 << (i % NR)));
            chk("rr_id", 64'({out_valid, id}), 64'({1'b1, 2'(i % NR)}));
        end

        // Backpressure: output held, nobody ready
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            chk("bp_ready", 64'(seen_ready), 64'h0);
            chk("bp_hold_id", 64'({out_valid, id}), 64'({1'b1, 2'd3}));
        end
        step(1'b1);
        chk("bp_release_ready", 64'(seen_ready), 64'(4'b0001));
        chk("bp_release_id", 64'({out_valid, id}), 64'({1'b1, 2'd0}));

        // Vector table: single requester active, drain and refill in one edge
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < NR; k++) vld[k] = 1'b0;
            vld[tbl[t].k] = 1'b1;
            opA[tbl[t].k] = tbl[t].op.a;
            opB[tbl[t].k] = tbl[t].op.b;
            cin[tbl[t].k] = tbl[t].op.carry;
            step(1'b1);
            chk("tbl_ready", 64'(seen_ready), 64'(1 << tbl[t].k));
            chk("tbl_result", 64'({out_valid, carry, id, result}),
                64'({1'b1, tbl[t].exp_c, 2'(tbl[t].k), tbl[t].exp_res}));
        end

        // Randomized traffic with random backpressure
        rand_mode = 1'b1;
        for (int k = 0; k < NR; k++) vld[k] = 1'($urandom_range(0, 1));
        n_hs = 0;
        cyc  = 0;
        while (n_hs < 10000 && cyc < 40000) begin
            step($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("random_budget", 64'(n_hs >= 10000), 64'(1));

        // Asynchronous reset while FULL, with the pointer away from 0
        rand_mode = 1'b0;
        for (int k = 0; k < NR; k++) vld[k] = 1'b0;
        step(1'b1);
        vld[1] = 1'b1;
        step(1'b0);
        chk("full_before_reset", 64'({out_valid, id}), 64'({1'b1, 2'd1}));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'h0);
        chk("async_outputs", dut_out(), 64'h0);
        chk("async_ready", 64'(req_ready), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < NR; k++) vld[k] = 1'b1;
        step(1'b1);
        chk("ptr_restart", 64'(seen_ready), 64'(4'b0001));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
